// File: rtl/blackjack_turn_controller.sv
// -----------------------------------------------------------------------------
// blackjack_turn_controller
//
// Runs one round of blackjack between a player and a dealer. Cards are dealt
// P, D, P, D, then the player hits or stays from button pulses. The dealer then
// draws until it reaches DEALER_STAND, and the two totals are compared.
// A hit pulse in END starts the next round.
//
// Ports
//   inclk0        system clock, all state changes on the rising edge
//   i_Reset       synchronous active-high reset
//   i_HitDown     one-cycle hit pulse (already debounced / edge detected)
//   i_StayDown    one-cycle stay pulse (already debounced / edge detected)
//   o_CardReq     request a card from the card source
//   i_CardValid   card source presents a card on i_CardValue
//   i_CardValue   rank: 1 = ace, 2..10 pip, 11..13 face; 0 and 14..15 are invalid
//   o_PlayerHand  player total
//   o_DealerHand  dealer total
//   o_Hit_P/D     high while the player/dealer is drawing a card
//   o_Stay_P/D    player/dealer has finished drawing
//   o_Win/Lose/Tie  round result, valid only in END
// -----------------------------------------------------------------------------
module blackjack_turn_controller #(
    parameter int DEALER_STAND = 17,
    parameter int MAX_TOTAL    = 21
) (
    input  logic       inclk0,
    input  logic       i_Reset,
    input  logic       i_HitDown,
    input  logic       i_StayDown,
    output logic       o_CardReq,
    input  logic       i_CardValid,
    input  logic [3:0] i_CardValue,
    output logic [4:0] o_PlayerHand,
    output logic [4:0] o_DealerHand,
    output logic       o_Hit_P,
    output logic       o_Hit_D,
    output logic       o_Stay_P,
    output logic       o_Stay_D,
    output logic       o_Win,
    output logic       o_Lose,
    output logic       o_Tie
);

    typedef enum logic [3:0] {
        DEAL_P1,
        DEAL_D1,
        DEAL_P2,
        DEAL_D2,
        PLAYER_WAIT,
        PLAYER_DRAW,
        DEALER_CHECK,
        DEALER_DRAW,
        COMPARE,
        END
    } stateType;

    localparam int PLAYER = 0;
    localparam int DEALER = 1;

    // Sums are formed at 6 bits so that total + 11 never wraps.
    localparam logic [5:0] maxTotal6    = 6'(MAX_TOTAL);
    localparam logic [5:0] dealerStand6 = 6'(DEALER_STAND);

    stateType   stateReg, stateNext;
    logic [4:0] handReg  [2];
    logic [4:0] handNext [2];
    logic       softReg  [2];
    logic       softNext [2];
    logic       stayPReg, stayPNext;
    logic       stayDReg, stayDNext;
    logic       winReg, winNext;
    logic       loseReg, loseNext;
    logic       tieReg, tieNext;

    // Hand totals after adding the presented card, one adder per hand.
    logic [4:0] addTotal [2];
    logic       addSoft  [2];

    logic       reqState;
    logic       cardOk;
    logic       accept;

    assign reqState = (stateReg == DEAL_P1) || (stateReg == DEAL_D1) ||
                      (stateReg == DEAL_P2) || (stateReg == DEAL_D2) ||
                      (stateReg == PLAYER_DRAW) || (stateReg == DEALER_DRAW);

    // The request is masked during reset so a pending draw is dropped at once.
    assign o_CardReq = reqState & ~i_Reset;
    assign cardOk    = (i_CardValue != 4'd0) && (i_CardValue <= 4'd13);
    assign accept    = o_CardReq & i_CardValid & cardOk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_hand
            logic [5:0] total6;
            logic [5:0] pips;
            logic [5:0] raw;
            logic       isAce;
            logic       aceHigh;
            logic       softRaw;
            logic [4:0] newTotal;
            logic       newSoft;

            always_comb begin
                total6  = {1'b0, handReg[gi]};
                isAce   = (i_CardValue == 4'd1);
                // Face cards count as 10; an ace's low value (1) falls out of pips.
                pips    = (i_CardValue >= 4'd10) ? 6'd10 : {2'b00, i_CardValue};
                aceHigh = isAce && ((total6 + 6'd11) <= maxTotal6);
                raw     = total6 + (aceHigh ? 6'd11 : pips);
                softRaw = softReg[gi] | aceHigh;
                // A soft hand that overflows demotes its 11-ace to 1 in the same update.
                if (softRaw && (raw > maxTotal6)) begin
                    newTotal = 5'(raw - 6'd10);
                    newSoft  = 1'b0;
                end else begin
                    newTotal = raw[4:0];
                    newSoft  = softRaw;
                end
            end

            assign addTotal[gi] = newTotal;
            assign addSoft[gi]  = newSoft;
        end
    endgenerate

    always_comb begin
        stateNext = stateReg;
        for (int i = 0; i < 2; i++) begin
            handNext[i] = handReg[i];
            softNext[i] = softReg[i];
        end
        stayPNext = stayPReg;
        stayDNext = stayDReg;
        winNext   = winReg;
        loseNext  = loseReg;
        tieNext   = tieReg;

        case (stateReg)
            DEAL_P1: begin
                if (accept) begin
                    handNext[PLAYER] = addTotal[PLAYER];
                    softNext[PLAYER] = addSoft[PLAYER];
                    stateNext        = DEAL_D1;
                end
            end
            DEAL_D1: begin
                if (accept) begin
                    handNext[DEALER] = addTotal[DEALER];
                    softNext[DEALER] = addSoft[DEALER];
                    stateNext        = DEAL_P2;
                end
            end
            DEAL_P2: begin
                if (accept) begin
                    handNext[PLAYER] = addTotal[PLAYER];
                    softNext[PLAYER] = addSoft[PLAYER];
                    stateNext        = DEAL_D2;
                end
            end
            DEAL_D2: begin
                if (accept) begin
                    handNext[DEALER] = addTotal[DEALER];
                    softNext[DEALER] = addSoft[DEALER];
                    // A two-card MAX_TOTAL is a natural: the player stands automatically.
                    if ({1'b0, handReg[PLAYER]} == maxTotal6) begin
                        stayPNext = 1'b1;
                        stateNext = DEALER_CHECK;
                    end else begin
                        stateNext = PLAYER_WAIT;
                    end
                end
            end
            PLAYER_WAIT: begin
                // Stay wins over a simultaneous hit.
                if (i_StayDown) begin
                    stayPNext = 1'b1;
                    stateNext = DEALER_CHECK;
                end else if (i_HitDown) begin
                    stateNext = PLAYER_DRAW;
                end
            end
            PLAYER_DRAW: begin
                if (accept) begin
                    handNext[PLAYER] = addTotal[PLAYER];
                    softNext[PLAYER] = addSoft[PLAYER];
                    if ({1'b0, addTotal[PLAYER]} > maxTotal6) begin
                        stateNext = COMPARE;
                    end else if ({1'b0, addTotal[PLAYER]} == maxTotal6) begin
                        stayPNext = 1'b1;
                        stateNext = DEALER_CHECK;
                    end else begin
                        stateNext = PLAYER_WAIT;
                    end
                end
            end
            DEALER_CHECK: begin
                if ({1'b0, handReg[DEALER]} < dealerStand6) begin
                    stateNext = DEALER_DRAW;
                end else begin
                    stayDNext = 1'b1;
                    stateNext = COMPARE;
                end
            end
            DEALER_DRAW: begin
                if (accept) begin
                    handNext[DEALER] = addTotal[DEALER];
                    softNext[DEALER] = addSoft[DEALER];
                    stateNext        = DEALER_CHECK;
                end
            end
            COMPARE: begin
                // A player bust loses even if the dealer's hand would also bust.
                if ({1'b0, handReg[PLAYER]} > maxTotal6) begin
                    loseNext = 1'b1;
                end else if ({1'b0, handReg[DEALER]} > maxTotal6) begin
                    winNext = 1'b1;
                end else if (handReg[PLAYER] > handReg[DEALER]) begin
                    winNext = 1'b1;
                end else if (handReg[PLAYER] < handReg[DEALER]) begin
                    loseNext = 1'b1;
                end else begin
                    tieNext = 1'b1;
                end
                stateNext = END;
            end
            END: begin
                if (i_HitDown) begin
                    for (int i = 0; i < 2; i++) begin
                        handNext[i] = 5'd0;
                        softNext[i] = 1'b0;
                    end
                    stayPNext = 1'b0;
                    stayDNext = 1'b0;
                    winNext   = 1'b0;
                    loseNext  = 1'b0;
                    tieNext   = 1'b0;
                    stateNext = DEAL_P1;
                end
            end
            default: begin
                stateNext = DEAL_P1;
            end
        endcase
    end

    always_ff @(posedge inclk0) begin
        if (i_Reset) begin
            stateReg <= DEAL_P1;
            for (int i = 0; i < 2; i++) begin
                handReg[i] <= 5'd0;
                softReg[i] <= 1'b0;
            end
            stayPReg <= 1'b0;
            stayDReg <= 1'b0;
            winReg   <= 1'b0;
            loseReg  <= 1'b0;
            tieReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            for (int i = 0; i < 2; i++) begin
                handReg[i] <= handNext[i];
                softReg[i] <= softNext[i];
            end
            stayPReg <= stayPNext;
            stayDReg <= stayDNext;
            winReg   <= winNext;
            loseReg  <= loseNext;
            tieReg   <= tieNext;
        end
    end

    assign o_PlayerHand = handReg[PLAYER];
    assign o_DealerHand = handReg[DEALER];
    assign o_Hit_P      = (stateReg == PLAYER_DRAW);
    assign o_Hit_D      = (stateReg == DEALER_DRAW);
    assign o_Stay_P     = stayPReg;
    assign o_Stay_D     = stayDReg;
    assign o_Win        = winReg;
    assign o_Lose       = loseReg;
    assign o_Tie        = tieReg;

endmodule

// File: tb/tb_blackjack_turn_controller.sv
// -----------------------------------------------------------------------------
// tb_blackjack_turn_controller
//
// Plays directed and random rounds against blackjack_turn_controller. The
// reference model keeps each hand as a list of ranks and scores it with the
// usual "aces as 1, promote one ace to 11 if it fits" rule, and plays the round
// flow (deal, player decisions, dealer draws to the stand value, compare).
// -----------------------------------------------------------------------------
module tb_blackjack_turn_controller;

    localparam int DEALER_STAND = 17;
    localparam int MAX_TOTAL    = 21;

    logic       inclk0 = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_HitDown = 1'b0;
    logic       i_StayDown = 1'b0;
    logic       o_CardReq;
    logic       i_CardValid = 1'b0;
    logic [3:0] i_CardValue = 4'd0;
    logic [4:0] o_PlayerHand;
    logic [4:0] o_DealerHand;
    logic       o_Hit_P, o_Hit_D, o_Stay_P, o_Stay_D;
    logic       o_Win, o_Lose, o_Tie;

    blackjack_turn_controller #(
        .DEALER_STAND(DEALER_STAND),
        .MAX_TOTAL   (MAX_TOTAL)
    ) dut (
        .inclk0      (inclk0),
        .i_Reset     (i_Reset),
        .i_HitDown   (i_HitDown),
        .i_StayDown  (i_StayDown),
        .o_CardReq   (o_CardReq),
        .i_CardValid (i_CardValid),
        .i_CardValue (i_CardValue),
        .o_PlayerHand(o_PlayerHand),
        .o_DealerHand(o_DealerHand),
        .o_Hit_P     (o_Hit_P),
        .o_Hit_D     (o_Hit_D),
        .o_Stay_P    (o_Stay_P),
        .o_Stay_D    (o_Stay_D),
        .o_Win       (o_Win),
        .o_Lose      (o_Lose),
        .o_Tie       (o_Tie)
    );

    always #5 inclk0 = ~inclk0;

    int vectors     = 0;
    int miscompares = 0;
    bit aborted     = 1'b0;

    int pCards[$];
    int dCards[$];
    int cardQ[$];   // directed card ranks, consumed before random ones
    int hitQ[$];    // directed player decisions: 1 = hit, 0 = stay

    task automatic checkResult(input string tag, input int got, input int expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge inclk0);
        #1;
    endtask

    function automatic int cardPoints(input int rank);
        return (rank >= 10) ? 10 : rank;
    endfunction

    function automatic int handTotal(input int cards[$]);
        int sum = 0;
        bit hasAce = 1'b0;
        foreach (cards[i]) begin
            sum += cardPoints(cards[i]);
            if (cards[i] == 1) hasAce = 1'b1;
        end
        if (hasAce && (sum + 10 <= MAX_TOTAL)) sum += 10;
        return sum;
    endfunction

    function automatic int nextRank();
        if (cardQ.size() > 0) return cardQ.pop_front();
        return int'($urandom_range(1, 13));
    endfunction

    task automatic checkHands(input string tag);
        checkResult({tag, "Player"}, int'(o_PlayerHand), handTotal(pCards));
        checkResult({tag, "Dealer"}, int'(o_DealerHand), handTotal(dCards));
    endtask

    task automatic checkCleared(input string tag);
        checkResult({tag, "Player"}, int'(o_PlayerHand), 0);
        checkResult({tag, "Dealer"}, int'(o_DealerHand), 0);
        checkResult({tag, "Leds"}, int'({o_Hit_P, o_Hit_D, o_Stay_P, o_Stay_D}), 0);
        checkResult({tag, "Result"}, int'({o_Win, o_Lose, o_Tie}), 0);
    endtask

    // Waits for a request, stalls, optionally offers an invalid rank, then
    // hands over one valid card. leds returns {o_Hit_P, o_Hit_D} seen at the request.
    task automatic serveCard(input int stalls, input bit bad, output int rank, output int leds);
        int waited = 0;
        rank = 0;
        leds = 0;
        if (aborted) return;
        while (o_CardReq !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (o_CardReq !== 1'b1) begin
            checkResult("cardReqTimeout", int'(o_CardReq), 1);
            aborted = 1'b1;
            return;
        end
        leds = int'({o_Hit_P, o_Hit_D});
        for (int s = 0; s < stalls; s++) begin
            i_CardValid = 1'b0;
            i_HitDown   = ($urandom_range(0, 3) == 0);
            i_StayDown  = ($urandom_range(0, 3) == 0);
            tick();
            i_HitDown  = 1'b0;
            i_StayDown = 1'b0;
            checkResult("reqHeldStall", int'(o_CardReq), 1);
        end
        if (bad) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            i_CardValid = 1'b1;
            i_CardValue = (sel == 0) ? 4'd0 : ((sel == 1) ? 4'd14 : 4'd15);
            tick();
            checkResult("reqHeldBadValue", int'(o_CardReq), 1);
            checkHands("badValue");
        end
        rank = nextRank();
        i_CardValid = 1'b1;
        i_CardValue = 4'(rank);
        tick();
        i_CardValid = 1'b0;
        i_CardValue = 4'd0;
        $display("card %0d accepted, player %0d dealer %0d", rank, o_PlayerHand, o_DealerHand);
    endtask

    task automatic serveRandom(output int rank, output int leds);
        serveCard(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), rank, leds);
    endtask

    // One full round from DEAL_P1 through END and the restart pulse.
    task automatic playRound(input int firstStalls);
        bit directed;
        bit bust;
        bit done;
        bit both;
        bit hit;
        bit gotResult;
        int rank, leds, pT, dT, expRes;
        directed  = (cardQ.size() > 0);
        bust      = 1'b0;
        done      = 1'b0;
        gotResult = 1'b0;
        pCards.delete();
        dCards.delete();

        for (int i = 0; i < 4; i++) begin
            if (i == 0 && firstStalls >= 0) serveCard(firstStalls, 1'b1, rank, leds);
            else serveRandom(rank, leds);
            if (aborted) return;
            checkResult("dealLeds", leds, 0);
            if (i % 2 == 0) pCards.push_back(rank);
            else dCards.push_back(rank);
            checkHands("deal");
        end

        pT = handTotal(pCards);
        if (pT == MAX_TOTAL) begin
            checkResult("naturalStayP", int'(o_Stay_P), 1);
            done = 1'b1;
        end

        while (!done) begin
            if (hitQ.size() > 0) hit = (hitQ.pop_front() != 0);
            else hit = (pT < int'($urandom_range(12, 19)));
            both = hit && !directed && ($urandom_range(0, 7) == 0);
            if (hit) begin
                i_HitDown  = 1'b1;
                i_StayDown = both;
                tick();
                i_HitDown  = 1'b0;
                i_StayDown = 1'b0;
                if (both) begin
                    checkResult("bothAsStayP", int'(o_Stay_P), 1);
                    checkResult("bothNoHitLed", int'(o_Hit_P), 0);
                    done = 1'b1;
                end else begin
                    checkResult("hitLedP", int'(o_Hit_P), 1);
                    serveRandom(rank, leds);
                    if (aborted) return;
                    checkResult("playerDrawLeds", leds, 2);
                    pCards.push_back(rank);
                    checkHands("playerDraw");
                    pT = handTotal(pCards);
                    if (pT > MAX_TOTAL) begin
                        bust = 1'b1;
                        done = 1'b1;
                    end else if (pT == MAX_TOTAL) begin
                        checkResult("autoStayP", int'(o_Stay_P), 1);
                        done = 1'b1;
                    end else begin
                        checkResult("hitLedOffP", int'(o_Hit_P), 0);
                    end
                end
            end else begin
                i_StayDown = 1'b1;
                tick();
                i_StayDown = 1'b0;
                checkResult("stayP", int'(o_Stay_P), 1);
                done = 1'b1;
            end
        end

        if (!bust) begin
            while (handTotal(dCards) < DEALER_STAND) begin
                serveRandom(rank, leds);
                if (aborted) return;
                checkResult("dealerDrawLeds", leds, 1);
                dCards.push_back(rank);
                checkHands("dealerDraw");
            end
        end

        // No further card may be requested; wait for the result to appear.
        for (int k = 0; k < 20; k++) begin
            checkResult("noReqAfterTurn", int'(o_CardReq), 0);
            if (o_Win | o_Lose | o_Tie) begin
                gotResult = 1'b1;
                break;
            end
            tick();
        end
        if (!gotResult) begin
            checkResult("resultTimeout", 0, 1);
            aborted = 1'b1;
            return;
        end

        pT = handTotal(pCards);
        dT = handTotal(dCards);
        if (pT > MAX_TOTAL)      expRes = 2;   // lose
        else if (dT > MAX_TOTAL) expRes = 4;   // win
        else if (pT > dT)        expRes = 4;
        else if (pT < dT)        expRes = 2;
        else                     expRes = 1;   // tie
        checkResult("result", int'({o_Win, o_Lose, o_Tie}), expRes);
        checkHands("end");
        checkResult("endStayP", int'(o_Stay_P), bust ? 0 : 1);
        checkResult("endStayD", int'(o_Stay_D), bust ? 0 : 1);
        checkResult("endHitLeds", int'({o_Hit_P, o_Hit_D}), 0);
        $display("round player %0d dealer %0d result win/lose/tie=%03b", pT, dT, {o_Win, o_Lose, o_Tie});

        if ($urandom_range(0, 1) == 1) begin
            i_StayDown = 1'b1;
            tick();
            i_StayDown = 1'b0;
            checkResult("endStayIgnored", int'({o_Win, o_Lose, o_Tie}), expRes);
            checkHands("endHold");
        end

        i_HitDown = 1'b1;
        tick();
        i_HitDown = 1'b0;
        checkCleared("newRound");
        checkResult("newRoundReq", int'(o_CardReq), 1);
        cardQ.delete();
        hitQ.delete();
    endtask

    // Reset lands while the dealer is drawing and a card is presented.
    task automatic resetDuringDealerDraw();
        int rank, leds, waited;
        waited = 0;
        pCards.delete();
        dCards.delete();
        cardQ = '{10, 5, 6, 2};
        for (int i = 0; i < 4; i++) begin
            serveRandom(rank, leds);
            if (aborted) return;
            if (i % 2 == 0) pCards.push_back(rank);
            else dCards.push_back(rank);
            checkHands("rstDeal");
        end
        i_HitDown  = 1'b1;
        i_StayDown = 1'b1;
        tick();
        i_HitDown  = 1'b0;
        i_StayDown = 1'b0;
        checkResult("rstBothAsStayP", int'(o_Stay_P), 1);
        checkResult("rstBothNoHitLed", int'(o_Hit_P), 0);
        while (o_CardReq !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (o_CardReq !== 1'b1) begin
            checkResult("rstDealerReqTimeout", int'(o_CardReq), 1);
            aborted = 1'b1;
            return;
        end
        checkResult("rstHitLedD", int'(o_Hit_D), 1);
        i_Reset     = 1'b1;
        i_CardValid = 1'b1;
        i_CardValue = 4'd5;
        tick();
        checkCleared("midDrawReset");
        checkResult("midDrawResetReq", int'(o_CardReq), 0);
        i_CardValid = 1'b0;
        i_CardValue = 4'd0;
        tick();
        checkResult("resetHoldReq", int'(o_CardReq), 0);
        i_Reset = 1'b0;
        #1;
        checkResult("reqRiseAfterReset", int'(o_CardReq), 1);
        $display("reset during dealer draw applied");
        cardQ.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with button pulses present must leave everything clear.
        for (int i = 0; i < 3; i++) begin
            i_HitDown  = (i == 1);
            i_StayDown = (i == 2);
            tick();
            checkCleared("reset");
            checkResult("resetReq", int'(o_CardReq), 0);
        end
        i_HitDown  = 1'b0;
        i_StayDown = 1'b0;
        i_Reset    = 1'b0;
        #1;
        checkResult("reqAfterReset", int'(o_CardReq), 1);

        // Basic stay, with a long stall and an invalid rank on the first card.
        cardQ = '{10, 7, 9, 10};
        hitQ  = '{0};
        playRound(5);

        if (!aborted) resetDuringDealerDraw();

        // Soft ace demoted by a hit, then stay.
        if (!aborted) begin
            cardQ = '{1, 10, 6, 7, 9};
            hitQ  = '{1, 0};
            playRound(-1);
        end
        // Natural for both hands.
        if (!aborted) begin
            cardQ = '{1, 10, 13, 1};
            playRound(-1);
        end
        // Player bust, dealer must not draw.
        if (!aborted) begin
            cardQ = '{10, 5, 6, 5, 10};
            hitQ  = '{1};
            playRound(-1);
        end

        for (int r = 0; r < 40 && !aborted; r++) begin
            playRound(-1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
